w_burst_writer: RTL and testbench
=================================

W_BURST_WRITER -- requirements
Module: w_burst_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, write data width in bits; STRB_WIDTH = DATA_WIDTH/8 derived.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have port W_wr_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port W_wr_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  burst command valid (from AW side).
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_addr  input  ADDR_WIDTH  burst start byte address.
REQ-008 SHALL have port cmd_len  input  8  beats minus one (AXI AWLEN).
REQ-009 SHALL have port cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 SHALL have port fifo_empty  input  1  upstream W FIFO empty flag.
REQ-011 SHALL have port fifo_r_en  output  1  pop request to W FIFO.
REQ-012 SHALL have port fifo_WDATA  input  DATA_WIDTH  popped data, valid cycle after pop.
REQ-013 SHALL have port fifo_WSTRB  input  STRB_WIDTH  popped byte strobes, valid cycle after pop.
REQ-014 SHALL have port fifo_WLAST  input  1  popped last flag, valid cycle after pop.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_addr  output  ADDR_WIDTH  word-aligned memory byte address.
REQ-017 SHALL have port mem_wdata  output  DATA_WIDTH  memory write data.
REQ-018 SHALL have port mem_be  output  STRB_WIDTH  memory byte enables.
REQ-019 SHALL have ports BVALID output 1, BREADY input 1, BRESP output 2: write response channel.

Function
REQ-020 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE; cmd_ready=1 only in IDLE.
REQ-021 In IDLE, on cmd_valid: latch addr (low log2(STRB_WIDTH) bits cleared), len, burst; clear error flag; enter DATA next cycle.
REQ-022 In DATA, fifo_r_en SHALL equal !fifo_empty AND pops_issued < len+1; never asserted while fifo_empty or in IDLE/RESP.
REQ-023 pops_issued and beats_written counters SHALL be 9 bits, cleared on command accept.
REQ-024 A registered rd_pending SHALL follow fifo_r_en by one cycle; when set, beat is consumed that cycle.
REQ-025 Beat consume: mem_we=1, mem_wdata=fifo_WDATA, mem_be=fifo_WSTRB, mem_addr=current address, combinationally, same cycle; mem_be=0 and mem_we=0 otherwise.
REQ-026 Throughput SHALL be one beat per cycle while FIFO non-empty; first mem_we no earlier than 2 cycles after command accept.
REQ-027 Address update after each beat: FIXED unchanged; INCR +STRB_WIDTH (ADDR_WIDTH modulo); WRAP +STRB_WIDTH wrapping within aligned (len+1)*STRB_WIDTH window.
REQ-028 WRAP with len not in {1,3,7,15}, or burst 11: error flag set, len+1 beats still popped, mem_we held 0 for the whole burst.
REQ-029 WLAST check: fifo_WLAST SHALL be 1 on beat len and 0 on all other beats; mismatch sets sticky error flag, beat still written, burst length still len+1.
REQ-030 On consuming beat len, FSM enters RESP next cycle; BVALID=1, BRESP=error?2'b10:2'b00.
REQ-031 BVALID and BRESP SHALL hold stable until BREADY=1; handshake cycle returns FSM to IDLE next cycle.
REQ-032 Command arriving while not IDLE SHALL wait (cmd_ready=0); no command queueing.

Reset
REQ-033 While W_wr_rst=1: FSM=IDLE, counters/error/rd_pending=0, fifo_r_en, mem_we, mem_be, BVALID, BRESP, cmd_ready = 0, mem_addr/mem_wdata = 0.
REQ-034 Reset mid-burst SHALL abandon the burst: no further writes, no B response; cmd_ready=1 first cycle after reset deasserts.

Verification
REQ-035 INCR len=3 addr 0x100, 4 beats preloaded, WLAST on 4th -> writes 0x100,0x104,0x108,0x10C on 4 consecutive cycles, BRESP=00.
REQ-036 WRAP len=3 addr 0x108 -> writes 0x108,0x10C,0x100,0x104; BRESP=00.
REQ-037 FIXED len=1 addr 0x40, strobes 0xF then 0x3 -> two writes at 0x40 with mem_be 0xF, 0x3.
REQ-038 INCR len=2, WLAST=1 on beat 1 -> 3 writes still performed, BRESP=10; BREADY held low 5 cycles -> BVALID stays 1, BRESP stable.
REQ-039 fifo_empty toggling every cycle during len=7 -> no fifo_r_en while empty, 8 in-order writes, no duplicates or drops.
REQ-040 Reset asserted after 2 of 4 beats -> next cycle all outputs 0, no BVALID; new command accepted after reset release.

Source files
------------

// File: rtl/w_burst_writer_if.sv
// Command, W-FIFO, memory-write and B-response signals of w_burst_writer.
// The slave modport is the writer's view; master is the surrounding system.
interface w_burst_writer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_len;
   logic [1:0]            cmd_burst;

   logic                  fifo_empty;
   logic                  fifo_r_en;
   logic [DATA_WIDTH-1:0] fifo_WDATA;
   logic [STRB_WIDTH-1:0] fifo_WSTRB;
   logic                  fifo_WLAST;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [STRB_WIDTH-1:0] mem_be;

   logic                  BVALID;
   logic                  BREADY;
   logic [1:0]            BRESP;

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, cmd_burst,
      input  fifo_empty, fifo_WDATA, fifo_WSTRB, fifo_WLAST,
      input  BREADY,
      output cmd_ready, fifo_r_en,
      output mem_we, mem_addr, mem_wdata, mem_be,
      output BVALID, BRESP
   );

   modport master (
      output cmd_valid, cmd_addr, cmd_len, cmd_burst,
      output fifo_empty, fifo_WDATA, fifo_WSTRB, fifo_WLAST,
      output BREADY,
      input  cmd_ready, fifo_r_en,
      input  mem_we, mem_addr, mem_wdata, mem_be,
      input  BVALID, BRESP
   );
endinterface

// File: rtl/w_burst_writer.sv
// Pops one AXI write burst from a W FIFO into a word-wide memory port,
// generating FIXED/INCR/WRAP addresses and a B response with error status.
module w_burst_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic             W_wr_clk,
   input logic             W_wr_rst,
   w_burst_writer_if.slave bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_BITS   = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(STRB_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [7:0]            len_reg;
   logic [1:0]            burst_reg;
   logic [8:0]            pops_reg;
   logic [8:0]            beats_reg;
   logic                  err_reg;
   logic                  bad_cmd_reg;
   logic                  rd_pending_reg;

   logic [8:0]            beats_total;
   logic                  cmd_accept;
   logic                  cmd_bad;
   logic                  r_en;
   logic                  consume;
   logic                  last_beat;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] step_addr;

   always_comb begin
      beats_total = {1'b0, len_reg} + 9'd1;
      cmd_accept  = (state_reg == IDLE) && bus.cmd_valid;
      // Reserved burst type, or a WRAP length that is not 2/4/8/16 beats
      cmd_bad     = (bus.cmd_burst == 2'b11) ||
                    ((bus.cmd_burst == 2'b10) &&
                     !((bus.cmd_len == 8'd1) || (bus.cmd_len == 8'd3) ||
                       (bus.cmd_len == 8'd7) || (bus.cmd_len == 8'd15)));
      r_en        = (state_reg == DATA) && !bus.fifo_empty && (pops_reg < beats_total);
      consume     = rd_pending_reg && (state_reg == DATA);
      last_beat   = consume && (beats_reg == {1'b0, len_reg});
      write_en    = consume && !bad_cmd_reg;
   end

   // WRAP keeps the bits above the (len+1)*STRB_WIDTH window and wraps below it
   always_comb begin
      wrap_mask = (ADDR_WIDTH'(len_reg) << OFF_BITS) | OFF_MASK;
      step_addr = addr_reg + ADDR_STEP;
      case (burst_reg)
         2'b00:   addr_next = addr_reg;
         2'b10:   addr_next = (addr_reg & ~wrap_mask) | (step_addr & wrap_mask);
         default: addr_next = step_addr;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.cmd_valid) state_next = DATA;
         DATA:    if (last_beat)     state_next = RESP;
         RESP:    if (bus.BREADY)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge W_wr_clk) begin
      if (W_wr_rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         len_reg        <= '0;
         burst_reg      <= '0;
         pops_reg       <= '0;
         beats_reg      <= '0;
         err_reg        <= 1'b0;
         bad_cmd_reg    <= 1'b0;
         rd_pending_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rd_pending_reg <= r_en;
         if (cmd_accept) begin
            addr_reg    <= bus.cmd_addr & ~OFF_MASK;
            len_reg     <= bus.cmd_len;
            burst_reg   <= bus.cmd_burst;
            pops_reg    <= '0;
            beats_reg   <= '0;
            err_reg     <= cmd_bad;
            bad_cmd_reg <= cmd_bad;
         end else begin
            if (r_en) begin
               pops_reg <= pops_reg + 9'd1;
            end
            if (consume) begin
               beats_reg <= beats_reg + 9'd1;
               addr_reg  <= addr_next;
               if (bus.fifo_WLAST != (beats_reg == {1'b0, len_reg})) begin
                  err_reg <= 1'b1;
               end
            end
         end
      end
   end

   // Outputs are gated by reset so they read zero during the reset cycle itself
   assign bus.cmd_ready = (state_reg == IDLE) && !W_wr_rst;
   assign bus.fifo_r_en = r_en && !W_wr_rst;
   assign bus.mem_we    = write_en && !W_wr_rst;
   assign bus.mem_addr  = W_wr_rst ? '0 : addr_reg;
   assign bus.mem_wdata = (write_en && !W_wr_rst) ? bus.fifo_WDATA : '0;
   assign bus.mem_be    = (write_en && !W_wr_rst) ? bus.fifo_WSTRB : '0;
   assign bus.BVALID    = (state_reg == RESP) && !W_wr_rst;
   assign bus.BRESP     = ((state_reg == RESP) && !W_wr_rst && err_reg) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_w_burst_writer.sv
// Directed and randomized bursts against a queue-based FIFO and address model
// of w_burst_writer; inputs change 1 time unit after posedge, outputs read at negedge.
module tb_w_burst_writer;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          l;
   } beat_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   w_burst_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   w_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .W_wr_clk (clk),
      .W_wr_rst (rst),
      .bus      (bus)
   );

   beat_t         fifo_q[$];
   wr_t           exp_q[$];
   logic [SW-1:0] strb_ovr[$];
   beat_t         staged;
   bit            have_staged = 0;
   bit            toggle_mode = 0;
   bit            gate = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            n_writes = 0;
   int            first_wr_cyc = 0;
   int            last_wr_cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   bit            cur_err;
   bit            cur_legal;
   int            cur_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte address of beat i, computed directly from the AXI burst rules
   function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int len,
                                                 input logic [1:0] burst, input int i);
      int unsigned win;
      logic [AW-1:0] start;
      case (burst)
         2'b00:   return base;
         2'b01:   return base + AW'(i * SW);
         default: begin
            win   = (len + 1) * SW;
            start = base - (base % win);
            return start + AW'((base - start + AW'(i * SW)) % win);
         end
      endcase
   endfunction

   task automatic sample_cycle();
      wr_t e;
      @(negedge clk);
      cyc++;
      if (bus.fifo_r_en) begin
         check("pop_while_empty", 64'(bus.fifo_empty), 64'd0);
         if (fifo_q.size() > 0) begin
            staged      = fifo_q.pop_front();
            have_staged = 1;
         end
      end
      if (bus.mem_we) begin
         if (n_writes == 0) begin
            first_wr_cyc = cyc;
            check("first_write_latency", 64'(cyc - acc_cyc >= 2), 64'd1);
         end
         last_wr_cyc = cyc;
         n_writes++;
         check("write_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_addr", 64'(bus.mem_addr), 64'(e.a));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(e.d));
            check("mem_be", 64'(bus.mem_be), 64'(e.s));
         end
      end else begin
         check("mem_be_idle", 64'(bus.mem_be), 64'd0);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (have_staged) begin
         bus.fifo_WDATA = staged.d;
         bus.fifo_WSTRB = staged.s;
         bus.fifo_WLAST = staged.l;
         have_staged    = 0;
      end
      gate           = toggle_mode ? ~gate : 1'b0;
      bus.fifo_empty = (fifo_q.size() == 0) || gate;
   endtask

   task automatic start_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                              input int bad_beat, input bit tog);
      beat_t b;
      wr_t   w;
      bit    accepted = 0;
      cur_len   = len;
      cur_legal = !((burst == 2'b11) ||
                    ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15)));
      cur_err   = !cur_legal;
      for (int i = 0; i <= len; i++) begin
         b.d = $urandom;
         b.s = (strb_ovr.size() > 0) ? strb_ovr.pop_front() : SW'($urandom_range(15, 1));
         b.l = (i == len);
         if (i == bad_beat) begin
            b.l     = ~b.l;
            cur_err = 1;
         end
         fifo_q.push_back(b);
         if (cur_legal) begin
            w.a = model_addr(addr & ~AW'(SW - 1), len, burst, i);
            w.d = b.d;
            w.s = b.s;
            exp_q.push_back(w);
         end
      end
      toggle_mode    = tog;
      n_writes       = 0;
      bus.fifo_empty = (fifo_q.size() == 0) || gate;
      bus.cmd_valid  = 1'b1;
      bus.cmd_addr   = addr;
      bus.cmd_len    = 8'(len);
      bus.cmd_burst  = burst;
      for (int k = 0; k < 20 && !accepted; k++) begin
         sample_cycle();
         if (bus.cmd_ready) begin
            accepted = 1;
            acc_cyc  = cyc;
         end
         advance();
      end
      check("cmd_accept", 64'(accepted), 64'd1);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_len   = 8'($urandom);
      bus.cmd_burst = 2'($urandom);
   endtask

   task automatic finish_burst(input int bready_delay);
      bit         got_b = 0;
      logic [1:0] bresp0;
      for (int k = 0; k < 300 && !got_b; k++) begin
         sample_cycle();
         if (bus.BVALID) got_b = 1;
         else advance();
      end
      check("bvalid_seen", 64'(got_b), 64'd1);
      check("bresp", 64'(bus.BRESP), cur_err ? 64'd2 : 64'd0);
      check("write_count", 64'(n_writes), cur_legal ? 64'(cur_len + 1) : 64'd0);
      check("exp_left", 64'(exp_q.size()), 64'd0);
      check("fifo_left", 64'(fifo_q.size()), 64'd0);
      if (cur_legal && !toggle_mode)
         check("consecutive_beats", 64'(last_wr_cyc - first_wr_cyc), 64'(cur_len));
      bresp0 = bus.BRESP;
      for (int d = 0; d < bready_delay; d++) begin
         advance();
         sample_cycle();
         check("bvalid_hold", 64'(bus.BVALID), 64'd1);
         check("bresp_hold", 64'(bus.BRESP), 64'(bresp0));
      end
      advance();
      bus.BREADY = 1'b1;
      sample_cycle();
      check("bvalid_handshake", 64'(bus.BVALID), 64'd1);
      advance();
      bus.BREADY  = 1'b0;
      toggle_mode = 0;
      sample_cycle();
      check("bvalid_clear", 64'(bus.BVALID), 64'd0);
      check("ready_after_b", 64'(bus.cmd_ready), 64'd1);
      advance();
      $display("burst done: len=%0d legal=%0d err=%0d writes=%0d", cur_len, cur_legal, cur_err, n_writes);
   endtask

   initial begin
      logic [1:0] rb;
      int         rl;
      bit         reached;
      rst            = 1'b1;
      bus.cmd_valid  = 1'b1;
      bus.cmd_addr   = 32'h1234;
      bus.cmd_len    = 8'd3;
      bus.cmd_burst  = 2'b01;
      bus.fifo_empty = 1'b1;
      bus.fifo_WDATA = '0;
      bus.fifo_WSTRB = '0;
      bus.fifo_WLAST = 1'b0;
      bus.BREADY     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("rst_r_en", 64'(bus.fifo_r_en), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_bvalid", 64'(bus.BVALID), 64'd0);
      check("rst_bresp", 64'(bus.BRESP), 64'd0);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      advance();

      // INCR 4 preloaded beats, WRAP from mid-window, FIXED with given strobes
      start_burst(32'h100, 3, 2'b01, -1, 0);
      finish_burst(0);
      start_burst(32'h108, 3, 2'b10, -1, 0);
      finish_burst(0);
      strb_ovr.push_back(4'hF);
      strb_ovr.push_back(4'h3);
      start_burst(32'h40, 1, 2'b00, -1, 0);
      finish_burst(0);
      // Early WLAST with BREADY held off; FIFO empty toggling; illegal bursts
      start_burst(32'h300, 2, 2'b01, 1, 0);
      finish_burst(5);
      start_burst(32'h400, 7, 2'b01, -1, 1);
      finish_burst(1);
      start_burst(32'h500, 2, 2'b10, -1, 0);
      finish_burst(0);
      start_burst(32'h600, 1, 2'b11, -1, 1);
      finish_burst(0);
      start_burst(32'hFFFF_FFF8, 3, 2'b01, -1, 0);
      finish_burst(0);

      // Reset after two of four beats abandons the burst
      start_burst(32'h200, 3, 2'b01, -1, 0);
      reached = 0;
      for (int k = 0; k < 50 && !reached; k++) begin
         sample_cycle();
         if (n_writes >= 2) reached = 1;
         else advance();
      end
      check("two_writes_before_reset", 64'(reached), 64'd1);
      advance();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("mid_rst_mem_be", 64'(bus.mem_be), 64'd0);
      check("mid_rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("mid_rst_r_en", 64'(bus.fifo_r_en), 64'd0);
      check("mid_rst_bvalid", 64'(bus.BVALID), 64'd0);
      check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      fifo_q.delete();
      exp_q.delete();
      advance();
      rst         = 1'b0;
      have_staged = 0;
      n_writes    = 0;
      for (int k = 0; k < 4; k++) begin
         sample_cycle();
         check("after_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
         check("after_rst_no_bvalid", 64'(bus.BVALID), 64'd0);
         advance();
      end
      check("after_rst_no_writes", 64'(n_writes), 64'd0);
      start_burst(32'h700, 3, 2'b01, -1, 0);
      finish_burst(0);

      // Randomized bursts
      for (int t = 0; t < 10; t++) begin
         rb = 2'($urandom_range(3, 0));
         case ($urandom_range(5, 0))
            0:       rl = 0;
            1:       rl = 1;
            2:       rl = 3;
            3:       rl = 7;
            4:       rl = 15;
            default: rl = $urandom_range(12, 2);
         endcase
         start_burst($urandom, rl, rb, ($urandom_range(3, 0) == 0) ? int'($urandom_range(rl, 0)) : -1,
                     bit'($urandom_range(1, 0)));
         finish_burst($urandom_range(3, 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
